// File: rtl/cache_arbiter_pkg.sv
// Shared types and sizes for the I/D-cache to physical-memory arbiter.
//   ARB_LINE_W / ARB_ADDR_W : default cache line and byte address widths
//   arb_state_t             : arbiter FSM states
//   arb_grant_t             : which cache owns (or last owned) the pmem port
package cache_arbiter_pkg;

  localparam int ARB_LINE_W = 256;
  localparam int ARB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Plain-vector copies of the state encoding for the FSM register.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_I_RD = I_RD;
  localparam logic [1:0] ST_D_RD = D_RD;
  localparam logic [1:0] ST_D_WR = D_WR;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and pmem signals seen by the arbiter.
//   slave  : arbiter view (takes cache requests and pmem responses,
//            drives cache responses and pmem strobes)
//   master : environment view (caches + memory), the mirror image
interface cache_arbiter_if #(
  parameter int LINE_W = cache_arbiter_pkg::ARB_LINE_W,
  parameter int ADDR_W = cache_arbiter_pkg::ARB_ADDR_W
) ();

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto the single pmem port,
// one whole-line transaction at a time, with one-bit round-robin fairness.
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : cache_arbiter_if.slave (cache requests/responses, pmem port)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; sample requests and grant one
// I_RD  | pmem line read on behalf of the I-cache
// D_RD  | pmem line read on behalf of the D-cache
// D_WR  | pmem line writeback on behalf of the D-cache
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_W = ARB_LINE_W,
  parameter int ADDR_W = ARB_ADDR_W
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  logic [1:0]        state, state_nxt;
  arb_grant_t        last_grant, grant_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;
  logic              i_req, d_req, pick_d;

  always_comb begin
    i_req     = bus.i_read;
    d_req     = bus.d_read | bus.d_write;
    // D wins when it is alone, or when both contend and I was served last.
    pick_d    = d_req && (!i_req || last_grant == GRANT_I);
    state_nxt = state;
    grant_nxt = last_grant;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      ST_IDLE: begin
        if (pick_d) begin
          grant_nxt = GRANT_D;
          addr_nxt  = bus.d_addr;
          if (bus.d_write) begin
            state_nxt = ST_D_WR;
            wdata_nxt = bus.d_wdata;
          end else begin
            state_nxt = ST_D_RD;
          end
        end else if (i_req) begin
          grant_nxt = GRANT_I;
          addr_nxt  = bus.i_addr;
          state_nxt = ST_I_RD;
        end
      end
      default: begin
        if (bus.pmem_resp) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  assign bus.pmem_read  = (state == ST_I_RD) || (state == ST_D_RD);
  assign bus.pmem_write = (state == ST_D_WR);
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;

  // Completion is combinational on pmem_resp so the cache sees the line
  // in the same cycle memory delivers it.
  assign bus.i_resp  = (state == ST_I_RD) && bus.pmem_resp;
  assign bus.d_resp  = ((state == ST_D_RD) || (state == ST_D_WR)) && bus.pmem_resp;
  assign bus.i_rdata = ((state == ST_I_RD) && bus.pmem_resp) ? bus.pmem_rdata : '0;
  assign bus.d_rdata = ((state == ST_D_RD) && bus.pmem_resp) ? bus.pmem_rdata : '0;

  // A D-cache read and writeback at once is illegal; the write wins above.
  a_no_d_rw: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int LW = ARB_LINE_W;
  localparam int AW = ARB_ADDR_W;
  localparam logic [LW-1:0] A5 = {32{8'hA5}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t req_i_q[$];
  txn_t req_d_q[$];
  txn_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int served = 0;

  bit directed = 1'b1;
  bit model_en = 1'b0;
  bit mon_en = 1'b0;
  bit mem_en = 1'b0;
  bit stop = 1'b0;
  bit i_done = 1'b0;
  bit d_done = 1'b0;
  bit model_busy = 1'b0;
  bit model_last_d = 1'b0;

  // Agent-driven and directly-driven copies of the environment signals.
  logic          ag_i_read, ag_d_read, ag_d_write, ag_pmem_resp;
  logic [AW-1:0] ag_i_addr, ag_d_addr;
  logic [LW-1:0] ag_d_wdata, ag_pmem_rdata;
  logic          dv_i_read, dv_d_read, dv_pmem_resp;
  logic [AW-1:0] dv_i_addr, dv_d_addr;
  logic [LW-1:0] dv_pmem_rdata;

  assign bus.i_read     = directed ? dv_i_read     : ag_i_read;
  assign bus.i_addr     = directed ? dv_i_addr     : ag_i_addr;
  assign bus.d_read     = directed ? dv_d_read     : ag_d_read;
  assign bus.d_write    = directed ? 1'b0          : ag_d_write;
  assign bus.d_addr     = directed ? dv_d_addr     : ag_d_addr;
  assign bus.d_wdata    = ag_d_wdata;
  assign bus.pmem_resp  = directed ? dv_pmem_resp  : ag_pmem_resp;
  assign bus.pmem_rdata = directed ? dv_pmem_rdata : ag_pmem_rdata;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: a single shared port serving one pending request at a
  // time; when both caches wait, the one not served last goes next.
  initial begin
    forever begin
      @(posedge clk);
      if (model_en && !rst) begin
        if (model_busy) begin
          if (bus.pmem_resp) model_busy = 1'b0;
        end else if (req_i_q.size() > 0 || req_d_q.size() > 0) begin
          bit take_d;
          take_d = (req_d_q.size() > 0) && (req_i_q.size() == 0 || !model_last_d);
          if (take_d) exp_q.push_back(req_d_q.pop_front());
          else        exp_q.push_back(req_i_q.pop_front());
          model_last_d = take_d;
          model_busy = 1'b1;
        end
      end
    end
  end

  // I-cache agent
  initial begin
    txn_t t;
    int gap, w;
    ag_i_read = 1'b0;
    ag_i_addr = '0;
    wait (model_en);
    for (int n = 0; !stop; n++) begin
      gap = (n < 8) ? 0 : int'($urandom_range(0, 3));
      if (gap > 0) begin
        ag_i_read = 1'b0;
        repeat (gap) @(negedge clk);
      end
      t.is_d = 1'b0;
      t.is_wr = 1'b0;
      t.addr = $urandom() & 32'hFFFF_FFE0;
      t.wdata = '0;
      ag_i_addr = t.addr;
      ag_i_read = 1'b1;
      req_i_q.push_back(t);
      w = 0;
      do begin
        @(negedge clk);
        #1;
        w++;
      end while (!bus.i_resp && w < 400);
      chk("i_resp_seen", bus.i_resp, 1'b1);
      if (!bus.i_resp) break;
      @(negedge clk);
    end
    ag_i_read = 1'b0;
    i_done = 1'b1;
  end

  // D-cache agent
  initial begin
    txn_t t;
    int gap, w;
    ag_d_read = 1'b0;
    ag_d_write = 1'b0;
    ag_d_addr = '0;
    ag_d_wdata = '0;
    wait (model_en);
    for (int n = 0; !stop; n++) begin
      gap = (n < 8) ? 0 : int'($urandom_range(0, 3));
      if (gap > 0) begin
        ag_d_read = 1'b0;
        ag_d_write = 1'b0;
        repeat (gap) @(negedge clk);
      end
      t.is_d = 1'b1;
      t.is_wr = ($urandom_range(0, 1) == 1);
      t.addr = $urandom() & 32'hFFFF_FFE0;
      t.wdata = t.is_wr ? rand_line() : '0;
      ag_d_addr = t.addr;
      ag_d_wdata = t.wdata;
      ag_d_read = !t.is_wr;
      ag_d_write = t.is_wr;
      req_d_q.push_back(t);
      w = 0;
      do begin
        @(negedge clk);
        #1;
        w++;
        // Once the writeback owns the port, scribble on its inputs.
        if (bus.pmem_write && !bus.d_resp) begin
          ag_d_wdata = rand_line();
          ag_d_addr = $urandom();
        end
      end while (!bus.d_resp && w < 400);
      chk("d_resp_seen", bus.d_resp, 1'b1);
      if (!bus.d_resp) break;
      @(negedge clk);
    end
    ag_d_read = 1'b0;
    ag_d_write = 1'b0;
    d_done = 1'b1;
  end

  // Memory agent: random latency, plus occasional spurious responses while idle.
  initial begin
    ag_pmem_resp = 1'b0;
    ag_pmem_rdata = '0;
    wait (mem_en);
    while (mem_en) begin
      @(negedge clk);
      ag_pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ag_pmem_rdata = rand_line();
        ag_pmem_resp = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        ag_pmem_rdata = rand_line();
        ag_pmem_resp = 1'b1;
      end
    end
    ag_pmem_resp = 1'b0;
  end

  // Monitor / scoreboard
  initial begin
    txn_t cur;
    bit in_txn;
    logic strobe, exp_ir, exp_dr;
    logic [LW-1:0] exp_ird, exp_drd;
    in_txn = 1'b0;
    cur.is_d = 1'b0;
    cur.is_wr = 1'b0;
    cur.addr = '0;
    cur.wdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        strobe = bus.pmem_read | bus.pmem_write;
        chk("strobe_excl", bus.pmem_read & bus.pmem_write, 1'b0);
        chk("port_busy", strobe, model_busy);
        if (strobe && !in_txn) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", strobe, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            in_txn = 1'b1;
            chk("txn_owner_addr", bus.pmem_addr, cur.addr);
            chk("txn_write", bus.pmem_write, cur.is_wr);
            chk("txn_read", bus.pmem_read, !cur.is_wr);
            if (cur.is_wr) chk("txn_wdata", bus.pmem_wdata, cur.wdata);
          end
        end else if (strobe && in_txn) begin
          chk("addr_hold", bus.pmem_addr, cur.addr);
          if (cur.is_wr) chk("wdata_hold", bus.pmem_wdata, cur.wdata);
        end
        exp_ir = in_txn && bus.pmem_resp && !cur.is_d;
        exp_dr = in_txn && bus.pmem_resp && cur.is_d;
        exp_ird = exp_ir ? bus.pmem_rdata : '0;
        exp_drd = (exp_dr && !cur.is_wr) ? bus.pmem_rdata : '0;
        chk("i_resp", bus.i_resp, exp_ir);
        chk("d_resp", bus.d_resp, exp_dr);
        chk("i_rdata", bus.i_rdata, exp_ird);
        chk("d_rdata", bus.d_rdata, exp_drd);
        if (in_txn && bus.pmem_resp) begin
          in_txn = 1'b0;
          served++;
        end
      end
    end
  end

  // Main sequence
  initial begin
    dv_i_read = 1'b0;
    dv_d_read = 1'b0;
    dv_i_addr = '0;
    dv_d_addr = '0;
    dv_pmem_resp = 1'b1;
    dv_pmem_rdata = A5;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_pmem_addr", bus.pmem_addr, '0);
    chk("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_i_resp", bus.i_resp, 1'b0);
    chk("rst_d_resp", bus.d_resp, 1'b0);
    chk("rst_i_rdata", bus.i_rdata, '0);
    chk("rst_d_rdata", bus.d_rdata, '0);

    // I-only read of line 0x60
    @(negedge clk);
    dv_pmem_resp = 1'b0;
    rst = 1'b0;
    dv_i_read = 1'b1;
    dv_i_addr = 32'h0000_0060;
    @(negedge clk);
    #2;
    chk("ionly_pmem_read", bus.pmem_read, 1'b1);
    chk("ionly_pmem_addr", bus.pmem_addr, 32'h60);
    repeat (2) @(negedge clk);
    dv_pmem_resp = 1'b1;
    dv_pmem_rdata = A5;
    #2;
    chk("ionly_i_resp", bus.i_resp, 1'b1);
    chk("ionly_i_rdata", bus.i_rdata, A5);
    chk("ionly_d_resp", bus.d_resp, 1'b0);
    @(negedge clk);
    dv_pmem_resp = 1'b0;
    dv_i_read = 1'b0;
    #2;
    chk("ionly_done", bus.pmem_read | bus.i_resp, 1'b0);

    // Randomized traffic against the reference model
    @(negedge clk);
    directed = 1'b0;
    model_en = 1'b1;
    mem_en = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 20000 && served < 80; c++) @(negedge clk);
    chk("random_served", (served >= 80), 1'b1);
    stop = 1'b1;
    for (int c = 0; c < 2000 && !(i_done && d_done); c++) @(negedge clk);
    chk("agents_done", i_done && d_done, 1'b1);
    repeat (6) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    mem_en = 1'b0;
    model_en = 1'b0;
    repeat (6) @(negedge clk);
    dv_pmem_resp = 1'b0;
    directed = 1'b1;

    // Spurious pmem_resp while idle
    @(negedge clk);
    dv_pmem_resp = 1'b1;
    dv_pmem_rdata = rand_line();
    #2;
    chk("spur_i_resp", bus.i_resp, 1'b0);
    chk("spur_d_resp", bus.d_resp, 1'b0);
    chk("spur_i_rdata", bus.i_rdata, '0);
    chk("spur_d_rdata", bus.d_rdata, '0);
    @(negedge clk);
    dv_pmem_resp = 1'b0;
    #2;
    chk("spur_idle", bus.pmem_read | bus.pmem_write, 1'b0);

    // Async reset in the middle of a D-cache read
    @(negedge clk);
    dv_d_read = 1'b1;
    dv_d_addr = 32'h0000_0200;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #2;
      if (bus.pmem_read) break;
    end
    chk("drd_pmem_read", bus.pmem_read, 1'b1);
    chk("drd_pmem_addr", bus.pmem_addr, 32'h200);
    #1;
    rst = 1'b1;
    dv_pmem_resp = 1'b1;
    #1;
    chk("arst_read_drop", bus.pmem_read, 1'b0);
    chk("arst_no_d_resp", bus.d_resp, 1'b0);
    @(negedge clk);
    #2;
    chk("arst_hold_d_resp", bus.d_resp, 1'b0);
    @(negedge clk);
    dv_pmem_resp = 1'b0;
    dv_d_read = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("post_rst_idle", bus.pmem_read | bus.pmem_write | bus.d_resp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
